// File: rtl/ula_pkg.sv
// Shared opcode constants, FSM state type and opcode-class helpers for ula_mdu.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ula_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_SLT   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_XOR   = 4'b0110;
  localparam logic [3:0] OP_NOR   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_MULT  = 4'b1011;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIV   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;
  localparam logic [3:0] OP_ADD2  = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/ula_muldiv.sv
// Iterative shift-add multiplier / restoring divider (divider only with ULA_MDU_DIV_EN).
// Latency: operands captured on start, WIDTH steps while run is high; done flags the last step.
// Backpressure: none; the owning FSM holds run low once done has been seen.
module ula_muldiv
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             run,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] p_hi, p_lo, m;
  logic             neg_res;
  logic [WIDTH-1:0] ma, mb, nxt_hi, nxt_lo;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] prod;

`ifdef ULA_MDU_DIV_EN
  logic             op_div, neg_rem, dz;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH:0]   shifted, diff;
`else
  logic unused_is_div;
  assign unused_is_div = is_div;
`endif

  // Operand magnitudes for the signed variants; the sign is restored at the end.
  assign ma = (is_signed && a[WIDTH-1]) ? -a : a;
  assign mb = (is_signed && b[WIDTH-1]) ? -b : b;
  assign done = run && (cnt == CW'(WIDTH - 1));

  // One iteration step plus sign/special-case fixup of the value it produces.
  always_comb begin
    sum    = {1'b0, p_hi} + (p_lo[0] ? {1'b0, m} : '0);
    nxt_hi = sum[WIDTH:1];
    nxt_lo = {sum[0], p_lo[WIDTH-1:1]};
    prod   = {nxt_hi, nxt_lo};
    if (neg_res) prod = -prod;
    hi_res   = prod[2*WIDTH-1:WIDTH];
    lo_res   = prod[WIDTH-1:0];
    div_zero = 1'b0;
`ifdef ULA_MDU_DIV_EN
    shifted = {p_hi, p_lo[WIDTH-1]};
    diff    = shifted - {1'b0, m};
    if (op_div) begin
      nxt_hi = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      nxt_lo = {p_lo[WIDTH-2:0], ~diff[WIDTH]};
      if (dz) begin
        lo_res   = '1;
        hi_res   = a_raw;
        div_zero = 1'b1;
      end else begin
        lo_res = neg_res ? -nxt_lo : nxt_lo;
        hi_res = neg_rem ? -nxt_hi : nxt_hi;
      end
    end
`endif
  end

  // Operand capture on start, then one step per cycle while the FSM runs us.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      p_hi    <= '0;
      p_lo    <= '0;
      m       <= '0;
      neg_res <= 1'b0;
`ifdef ULA_MDU_DIV_EN
      op_div  <= 1'b0;
      neg_rem <= 1'b0;
      dz      <= 1'b0;
      a_raw   <= '0;
`endif
    end else if (start) begin
      cnt     <= '0;
      p_hi    <= '0;
      neg_res <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef ULA_MDU_DIV_EN
      op_div  <= is_div;
      neg_rem <= is_signed & a[WIDTH-1];
      dz      <= (b == '0);
      a_raw   <= a;
      if (is_div) begin
        m    <= mb;
        p_lo <= ma;
      end else begin
        m    <= ma;
        p_lo <= mb;
      end
`else
      m    <= ma;
      p_lo <= mb;
`endif
    end else if (run) begin
      p_hi <= nxt_hi;
      p_lo <= nxt_lo;
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ula_mdu.sv
// ALU with iterative mult/div unit; build with ULA_MDU_DIV_EN to include the divider.
// Latency: 1 cycle for ALU ops, WIDTH+1 cycles for mult/multu (and div/divu when enabled).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module ula_mdu
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ula_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             overflow,
  output logic             div_zero
);

  localparam int SW = $clog2(WIDTH);

  state_t           state;
  logic             accept, op_mul, op_div, md_start, md_run, md_signed;
  logic             md_done, md_dz;
  logic [WIDTH-1:0] md_hi, md_lo;
  logic [WIDTH-1:0] alu_res, add_sum, sub_dif;
  logic             alu_ovf;
  logic [SW-1:0]    shamt;

  assign in_ready  = (state == S_IDLE) && !reset;
  assign accept    = in_valid && in_ready;
  assign op_mul    = is_mul_op(ula_control);
  assign op_div    = is_div_op(ula_control);
  assign md_signed = (ula_control == OP_MULT) || (ula_control == OP_DIV);
  assign md_run    = (state == S_MUL) || (state == S_DIV);
`ifdef ULA_MDU_DIV_EN
  assign md_start  = accept && (op_mul || op_div);
`else
  assign md_start  = accept && op_mul;
`endif
  assign shamt   = b[SW-1:0];
  assign add_sum = a + b;
  assign sub_dif = a - b;

  ula_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .reset     (reset),
    .start     (md_start),
    .run       (md_run),
    .is_div    (op_div),
    .is_signed (md_signed),
    .a         (a),
    .b         (b),
    .done      (md_done),
    .hi_res    (md_hi),
    .lo_res    (md_lo),
    .div_zero  (md_dz)
  );

  // Single-cycle ALU result and signed add/sub overflow.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ula_control)
      OP_ADD, OP_ADD2: begin
        alu_res = add_sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_dif;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // Control FSM with registered result, flags and out_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      hi        <= '0;
      lo        <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (op_mul) begin
              state <= S_MUL;
`ifdef ULA_MDU_DIV_EN
            end else if (op_div) begin
              state <= S_DIV;
`else
            end else if (op_div) begin
              result    <= '0;
              zero      <= 1'b1;
              overflow  <= 1'b0;
              div_zero  <= 1'b1;
              out_valid <= 1'b1;
              state     <= S_DONE;
`endif
            end else begin
              result    <= alu_res;
              zero      <= (alu_res == '0);
              overflow  <= alu_ovf;
              div_zero  <= 1'b0;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (md_done) begin
            hi        <= md_hi;
            lo        <= md_lo;
            result    <= md_lo;
            zero      <= (md_lo == '0);
            overflow  <= 1'b0;
            div_zero  <= md_dz;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_mdu.sv
// Self-checking bench for ula_mdu: directed vector table, hand-written handshake/reset sequences
// and randomized operations checked against an arithmetic reference model.
// Follows ULA_MDU_DIV_EN so the div/divu expectations match the build.
module tb_ula_mdu;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset, in_valid, out_ready;
  logic          in_ready, out_valid, zero, overflow, div_zero;
  logic [W-1:0]  a, b, result, hi, lo;
  logic [3:0]    ula_control;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] result, hi, lo;
    logic        zero, ovf, dz;
    int          lat;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, res, hi, lo;
    logic        use_hl, z, ovf, dz;
    int          lat;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] trk_hi, trk_lo;

  ula_mdu #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .ula_control (ula_control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .hi          (hi),
    .lo          (lo),
    .zero        (zero),
    .overflow    (overflow),
    .div_zero    (div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic cmp_all(input string tag, input exp_t g, input exp_t e);
    chk({tag, ".result"}, 64'(g.result), 64'(e.result));
    chk({tag, ".hi"},     64'(g.hi),     64'(e.hi));
    chk({tag, ".lo"},     64'(g.lo),     64'(e.lo));
    chk({tag, ".zero"},   64'(g.zero),   64'(e.zero));
    chk({tag, ".ovf"},    64'(g.ovf),    64'(e.ovf));
    chk({tag, ".dz"},     64'(g.dz),     64'(e.dz));
    chk({tag, ".lat"},    64'(g.lat),    64'(e.lat));
  endtask

  // Reference model: the architectural result computed with wide integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] phi, input logic [31:0] plo);
    exp_t e;
    longint sx, sy, s, q, r;
    logic [63:0] p;
    int sh;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = int'(y[4:0]);
    e.hi = phi; e.lo = plo; e.ovf = 1'b0; e.dz = 1'b0; e.lat = 1; e.result = '0;
    case (op)
      4'd0, 4'd15: begin
        s = sx + sy; e.result = x + y;
        e.ovf = (s != longint'($signed(e.result)));
      end
      4'd1: begin
        s = sx - sy; e.result = x - y;
        e.ovf = (s != longint'($signed(e.result)));
      end
      4'd2:  e.result = x & y;
      4'd3:  e.result = x | y;
      4'd4:  e.result = (sx < sy) ? 32'd1 : 32'd0;
      4'd5:  e.result = (x < y) ? 32'd1 : 32'd0;
      4'd6:  e.result = x ^ y;
      4'd7:  e.result = ~(x | y);
      4'd8:  e.result = x << sh;
      4'd9:  e.result = x >> sh;
      4'd10: e.result = x[31] ? ~((~x) >> sh) : (x >> sh);
      4'd11: begin
        p = sx * sy; e.hi = p[63:32]; e.lo = p[31:0]; e.result = e.lo; e.lat = 33;
      end
      4'd12: begin
        p = {32'd0, x} * {32'd0, y}; e.hi = p[63:32]; e.lo = p[31:0]; e.result = e.lo; e.lat = 33;
      end
      default: begin
`ifdef ULA_MDU_DIV_EN
        e.lat = 33;
        if (y == 32'd0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = x; e.dz = 1'b1;
        end else if (op == 4'd13) begin
          q = sx / sy; r = sx % sy;
          e.lo = q[31:0]; e.hi = r[31:0];
        end else begin
          e.lo = x / y; e.hi = x % y;
        end
        e.result = e.lo;
`else
        e.result = '0; e.dz = 1'b1;
`endif
      end
    endcase
    e.zero = (e.result == 32'd0);
    return e;
  endfunction

  // Issue one request, wait (bounded) for out_valid, capture outputs, then release.
  task automatic do_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       input int hold, output exp_t got);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    in_valid = 1'b1; ula_control = op; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom; ula_control = 4'($urandom);
    got.lat = 1;
    while (!out_valid && got.lat < 100) begin
      in_valid = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      got.lat++;
      a = $urandom; b = $urandom;
    end
    in_valid = 1'b0;
    got.result = result; got.hi = hi; got.lo = lo;
    got.zero = zero; got.ovf = overflow; got.dz = div_zero;
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("release", 64'({out_valid, in_ready}), 64'(2'b01));
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] res, input logic [31:0] vh, input logic [31:0] vl,
                         input logic use_hl, input logic z, input logic o, input logic d,
                         input int lat);
    vec_t v;
    v.op = op; v.a = x; v.b = y; v.res = res; v.hi = vh; v.lo = vl;
    v.use_hl = use_hl; v.z = z; v.ovf = o; v.dz = d; v.lat = lat;
    tbl.push_back(v);
  endtask

  initial begin
    exp_t g, e;
    logic [3:0]  op;
    logic [31:0] x, y;
    logic        seen;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; ula_control = '0;
    trk_hi = '0; trk_lo = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset.in_ready_during", 64'(in_ready), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("reset.in_ready_after", 64'(in_ready), 64'd1);
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.result", 64'(result), 64'd0);
    chk("reset.hilo", {hi, lo}, 64'd0);
    chk("reset.flags", 64'({zero, overflow, div_zero}), 64'd0);

    // Directed vectors: op, a, b, result, hi, lo, use_hl, zero, ovf, dz, latency
    add_vec(4'd0,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 0, 0, 0, 0, 1, 0, 1);
    add_vec(4'd0,  32'hFFFF_FFFF, 32'h1,         32'h0,         0, 0, 0, 1, 0, 0, 1);
    add_vec(4'd1,  32'd5,         32'd5,         32'h0,         0, 0, 0, 1, 0, 0, 1);
    add_vec(4'd1,  32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 0, 0, 0, 0, 1, 0, 1);
    add_vec(4'd4,  32'hFFFF_FFFF, 32'h1,         32'h1,         0, 0, 0, 0, 0, 0, 1);
    add_vec(4'd5,  32'hFFFF_FFFF, 32'h1,         32'h0,         0, 0, 0, 1, 0, 0, 1);
    add_vec(4'd10, 32'h8000_0000, 32'd4,         32'hF800_0000, 0, 0, 0, 0, 0, 0, 1);
    add_vec(4'd10, 32'h8000_0000, 32'h20,        32'h8000_0000, 0, 0, 0, 0, 0, 0, 1);
    add_vec(4'd8,  32'h1,         32'd31,        32'h8000_0000, 0, 0, 0, 0, 0, 0, 1);
    add_vec(4'd8,  32'h1234_5678, 32'd0,         32'h1234_5678, 0, 0, 0, 0, 0, 0, 1);
    add_vec(4'd9,  32'h8000_0000, 32'd31,        32'h1,         0, 0, 0, 0, 0, 0, 1);
    add_vec(4'd2,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 0, 0, 0, 0, 0, 0, 1);
    add_vec(4'd3,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 1);
    add_vec(4'd6,  32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 0, 0, 0, 0, 0, 0, 1);
    add_vec(4'd7,  32'hFFFF_FFFF, 32'h0,         32'h0,         0, 0, 0, 1, 0, 0, 1);
    add_vec(4'd15, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 0, 0, 0, 0, 1, 0, 1);
    add_vec(4'd11, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1, 0, 0, 0, 33);
    add_vec(4'd0,  32'd1,         32'd1,         32'd2,         0, 0, 0, 0, 0, 0, 1);
    add_vec(4'd12, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFF9, 1, 0, 0, 0, 33);
    add_vec(4'd11, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h4000_0000, 32'h0, 1, 1, 0, 0, 33);
`ifdef ULA_MDU_DIV_EN
    add_vec(4'd13, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1, 0, 0, 0, 33);
    add_vec(4'd14, 32'd9,         32'd0, 32'hFFFF_FFFF, 32'd9,         32'hFFFF_FFFF, 1, 0, 0, 1, 33);
    add_vec(4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'h8000_0000, 1, 0, 0, 0, 33);
    add_vec(4'd14, 32'd100,       32'd7, 32'd14,        32'd2,         32'd14,        1, 0, 0, 0, 33);
    add_vec(4'd13, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFFD, 1, 0, 0, 0, 33);
`else
    add_vec(4'd13, 32'hFFFF_FFF9, 32'd2, 32'h0, 0, 0, 0, 1, 0, 1, 1);
    add_vec(4'd14, 32'd9,         32'd0, 32'h0, 0, 0, 0, 1, 0, 1, 1);
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, i % 3, g);
      e.result = tbl[i].res;
      e.hi = tbl[i].use_hl ? tbl[i].hi : trk_hi;
      e.lo = tbl[i].use_hl ? tbl[i].lo : trk_lo;
      e.zero = tbl[i].z; e.ovf = tbl[i].ovf; e.dz = tbl[i].dz; e.lat = tbl[i].lat;
      cmp_all($sformatf("vec%0d_op%0h", i, tbl[i].op), g, e);
      trk_hi = e.hi; trk_lo = e.lo;
    end

    // Held result in DONE: outputs stable, requests ignored, release on out_ready
    while (!in_ready) @(negedge clk);
    in_valid = 1'b1; ula_control = 4'd0; a = 32'd3; b = 32'd4;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d.result", i), 64'(result), 64'd7);
      chk($sformatf("hold%0d.valid_ready", i), 64'({out_valid, in_ready}), 64'(2'b10));
      in_valid = 1'($urandom); ula_control = 4'($urandom); a = $urandom; b = $urandom;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold.release", 64'({out_valid, in_ready}), 64'(2'b01));
    chk("hold.hilo_kept", {hi, lo}, {trk_hi, trk_lo});

    // Randomized operations against the reference model
    for (int i = 0; i < 120; i++) begin
      op = 4'($urandom_range(0, 15)); x = $urandom; y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = y & 32'h3F;
        3: x = x & 32'hFF;
        default: ;
      endcase
      e = model(op, x, y, trk_hi, trk_lo);
      do_op(op, x, y, $urandom_range(0, 2), g);
      cmp_all($sformatf("rnd%0d_op%0h", i, op), g, e);
      trk_hi = e.hi; trk_lo = e.lo;
    end

    // Reset during cycle 10 of a multiply aborts it and clears hi/lo
    while (!in_ready) @(negedge clk);
    in_valid = 1'b1; ula_control = 4'd11; a = 32'd9; b = 32'd9;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort.in_ready_in_reset", 64'(in_ready), 64'd0);
    reset = 1'b0;
    chk("abort.hilo", {hi, lo}, 64'd0);
    chk("abort.result", 64'(result), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen |= out_valid;
      @(posedge clk);
      @(negedge clk);
    end
    chk("abort.no_out_valid", 64'(seen), 64'd0);
    do_op(4'd11, 32'd5, 32'd6, 0, g);
    e.result = 32'd30; e.hi = 32'd0; e.lo = 32'd30;
    e.zero = 1'b0; e.ovf = 1'b0; e.dz = 1'b0; e.lat = 33;
    cmp_all("abort.next_mult", g, e);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ula_mdu.md
ULA_MDU -- requirements
Module: ula_mdu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits (even, >= 8).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block accepts a request this cycle.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B (its low log2(WIDTH) bits are the shift amount for shifts).
REQ-008 ula_control  input  4  opcode, encoded per REQ-012.
REQ-009 out_valid  output  1  result, zero, overflow, div_zero, hi, lo valid.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 result / hi / lo  output  WIDTH each; zero / overflow / div_zero  output  1 each; all registered.

Function
REQ-012 Opcodes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 slt signed, 0101 sltu, 0110 xor, 0111 nor, 1000 sll, 1001 srl, 1010 sra, 1011 mult, 1100 multu, 1101 div, 1110 divu, 1111 treated as add.
REQ-013 FSM states IDLE, MUL, DIV, DONE; in_ready = 1 only in IDLE.
REQ-014 Accept (in_valid & in_ready) of opcodes 0000-1010, 1111: result computed and latched, IDLE -> DONE; out_valid asserted the next cycle (latency 1).
REQ-015 Accept of mult/multu: IDLE -> MUL; shift-add iteration, one bit per cycle, exactly WIDTH cycles, then -> DONE (out_valid WIDTH+1 cycles after accept).
REQ-016 Accept of div/divu: IDLE -> DIV; restoring division, exactly WIDTH cycles, then -> DONE; same latency as REQ-015.
REQ-017 mult: {hi,lo} = full 2*WIDTH-bit product; signed for mult (magnitude product, negated when signs differ), unsigned for multu.
REQ-018 div: lo = quotient, hi = remainder; signed div truncates toward zero, remainder takes the sign of a; divu unsigned.
REQ-019 Divide by zero: lo = all ones, hi = a, div_zero = 1; latency unchanged.
REQ-020 Signed most-negative / -1: lo = most-negative value, hi = 0, div_zero = 0.
REQ-021 For mult/div, result = new lo; for all other ops hi and lo hold their previous values.
REQ-022 zero = (result == 0); overflow = 1 only on signed overflow of add/sub, else 0; div_zero = 0 except REQ-019.
REQ-023 slt/sltu: result = 1 or 0, zero-extended to WIDTH.
REQ-024 Shifts: sll/srl logical, sra arithmetic, amount 0 returns a unchanged.
REQ-025 DONE: out_valid = 1; outputs held stable until out_ready = 1, then -> IDLE next cycle; out_ready ignored outside DONE.
REQ-026 Operands and opcode captured at accept; input changes during MUL/DIV/DONE have no effect.

Reset
REQ-027 reset = 1: state IDLE, iteration counter 0, result/hi/lo = 0, zero/overflow/div_zero = 0, out_valid = 0, in_ready = 0 during the reset cycle, 1 the cycle after.
REQ-028 reset asserted mid-MUL/DIV/DONE aborts the operation; no out_valid is produced for it and hi/lo are cleared.

Configuration
REQ-029 Macro ULA_MDU_DIV_EN defined: div/divu per REQ-016 to REQ-020.
REQ-030 Macro undefined: no divider logic; div/divu complete with latency 1, result = 0, hi/lo unchanged, div_zero = 1.

Structure
REQ-031 Package ula_pkg holds opcode constants (REQ-012) and the FSM state type; shared with decode logic.
REQ-032 Iterative datapath (partial-product/remainder registers, counter) is sub-module ula_muldiv; ula_mdu holds FSM, single-cycle ops and output registers.

Verification
REQ-033 WIDTH=32, add 0x7FFFFFFF+1 -> result 0x80000000, overflow 1, zero 0, out_valid 1 cycle after accept.
REQ-034 sub 5-5 -> result 0, zero 1; slt 0xFFFFFFFF,1 -> 1; sltu same operands -> 0; sra 0x80000000 by 4 -> 0xF8000000.
REQ-035 mult 0xFFFFFFFF (-1) * 7 -> hi 0xFFFFFFFF, lo 0xFFFFFFF9, out_valid exactly 33 cycles after accept; multu same -> hi 0x00000006, lo 0xFFFFFFF9.
REQ-036 div -7/2 -> lo 0xFFFFFFFD, hi 0xFFFFFFFF; divu 9/0 -> lo 0xFFFFFFFF, hi 9, div_zero 1 (macro defined).
REQ-037 out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready 0, in_valid pulses ignored; then out_ready 1 -> IDLE next cycle.
REQ-038 reset asserted at cycle 10 of mult -> no out_valid, hi/lo 0, next request executes correctly.
